spi_xfer_controller: RTL
========================

SPI_XFER_CONTROLLER -- requirements
Module: spi_xfer_controller

Interface
REQ-001: One clock; reset is asynchronous and active-high; ports named PCLK and PRESET.
REQ-002: PCLK  input  1  system clock; all state updates on its rising edge.
REQ-003: PRESET  input  1  asynchronous active-high reset.
REQ-004: mstr_i  input  1  master enable; 0 aborts or blocks all frames.
REQ-005: spi_mode_i  input  2  00 RUN, 01 WAIT, 10/11 STOP.
REQ-006: spiswai_i  input  1  in WAIT, 1 halts the SPI.
REQ-007: send_data_i  input  1  single-cycle frame request strobe.
REQ-008: BaudRateDivisor_i  input  12  SCLK period in PCLK cycles, from the baud generator.
REQ-009: ss_o  output  1  active-low slave select.
REQ-010: tip_o  output  1  transfer in progress.
REQ-011: load_o  output  1  one-cycle pulse to load the transmit shift register at frame start.
REQ-012: receive_data_o  output  1  one-cycle pulse at frame completion.
REQ-013: abort_o  output  1  one-cycle pulse when a frame is aborted.
REQ-014: err_o  output  1  one-cycle pulse when a request is dropped for a zero divisor.
REQ-015: pending_o  output  1  one request queued.

Function
REQ-016: The controller SHALL compute en = mstr_i & (spi_mode_i==00 | (spi_mode_i==01 & ~spiswai_i)).
REQ-017: The FSM SHALL have three states, IDLE, ACTIVE and DONE, with IDLE as the reset state.
REQ-018: A start condition SHALL be: state IDLE or DONE, request present (send_data_i or pending), en=1 and BaudRateDivisor_i!=0.
REQ-019: On a start, at the next edge the FSM SHALL enter ACTIVE, drive ss_o=0 and tip_o=1, and pulse load_o for exactly one cycle.
REQ-020: On a start, the controller SHALL latch frame length L = 8*BaudRateDivisor_i into a 15-bit register, clear the cycle counter and clear pending.
REQ-021: Divisor changes during ACTIVE SHALL NOT affect the current frame.
REQ-022: In ACTIVE with en=1, the counter SHALL increment once per cycle.
REQ-023: In ACTIVE with en=0 and mstr_i=1, the counter SHALL freeze and ss_o/tip_o SHALL hold; counting resumes when en returns.
REQ-024: When the counter equals L-1 with en=1, the next edge SHALL enter DONE with ss_o=1, tip_o=0 and receive_data_o=1 for one cycle; ss_o is therefore low for exactly L enabled cycles.
REQ-025: DONE SHALL last one cycle, going to ACTIVE on a start condition and to IDLE otherwise.
REQ-026: The minimum ss_o high gap between back-to-back frames SHALL be one cycle.
REQ-027: send_data_i in ACTIVE, in DONE, or in IDLE with en=0 SHALL set pending.
REQ-028: send_data_i while pending=1 SHALL be ignored, giving a one-deep queue.
REQ-029: A request at a start point with BaudRateDivisor_i==0 and en=1 SHALL pulse err_o, clear pending and leave the FSM in IDLE.
REQ-030: mstr_i=0 in any state SHALL clear pending at the next edge.
REQ-031: mstr_i=0 in ACTIVE SHALL, at the next edge, go to IDLE with ss_o=1, tip_o=0, abort_o pulsed and no receive_data_o.
REQ-032: If abort and the final count coincide, abort SHALL win.
REQ-033: All outputs SHALL be registered.

Reset
REQ-034: PRESET=1 SHALL immediately force state IDLE, ss_o=1 and tip_o, load_o, receive_data_o, abort_o, err_o, pending_o=0, counter=0, L=0, including mid-frame.
REQ-035: After PRESET deasserts, the first start SHALL be accepted at the first rising edge.

Verification
REQ-036: Start test: divisor=4, RUN, mstr=1, send_data at cycle 0 -> load_o at cycle 1, ss_o low cycles 1-32, receive_data_o at cycle 33, ss_o=1 at cycle 33.
REQ-037: Back-to-back test: divisor=2, second send_data at cycle 5 of frame 1 -> pending_o=1, ss_o high exactly 1 cycle, then a second 16-cycle frame.
REQ-038: Stall test: WAIT with spiswai_i=1 for 10 cycles mid-frame (divisor=4) -> ss_o low for 42 cycles total, a single receive_data_o.
REQ-039: Abort and zero-divisor test: mstr_i=0 at count 7 -> abort_o pulse, ss_o=1 next cycle, no receive_data_o; divisor=0 request -> err_o pulse, ss_o stays 1.
REQ-040: Reset test: PRESET mid-frame -> ss_o=1 asynchronously, pending_o=0, next request starts a fresh full-length frame.

Source files
------------

// File: rtl/spi_xfer_controller.sv
// spi_xfer_controller: sequences SPI frames of 8*divisor enabled PCLK cycles, with
// WAIT/STOP stalling, a one-deep request queue, master abort and zero-divisor rejection.
module spi_xfer_controller (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        mstr_i,
  input  logic [1:0]  spi_mode_i,
  input  logic        spiswai_i,
  input  logic        send_data_i,
  input  logic [11:0] BaudRateDivisor_i,
  output logic        ss_o,
  output logic        tip_o,
  output logic        load_o,
  output logic        receive_data_o,
  output logic        abort_o,
  output logic        err_o,
  output logic        pending_o
);

  localparam int unsigned DIV_W = 12;
  localparam int unsigned LEN_W = DIV_W + 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [LEN_W-1:0] w_len_nxt;

  logic w_en;
  logic w_req;
  logic w_start_pt;
  logic w_div_zero;
  logic w_start;
  logic w_err;
  logic w_abort;
  logic w_last;

  logic w_ss_nxt;
  logic w_tip_nxt;
  logic w_load_nxt;
  logic w_rx_nxt;
  logic w_abort_nxt;
  logic w_err_nxt;
  logic w_pending_nxt;

  // Qualifying conditions; w_last already implies mstr_i=1, so abort always wins.
  always_comb begin
    w_en       = mstr_i & ((spi_mode_i == 2'b00) | ((spi_mode_i == 2'b01) & ~spiswai_i));
    w_req      = send_data_i | pending_o;
    w_start_pt = (r_state == ST_IDLE) | (r_state == ST_DONE);
    w_div_zero = (BaudRateDivisor_i == '0);
    w_start    = w_start_pt & w_req & w_en & ~w_div_zero;
    w_err      = w_start_pt & w_req & w_en & w_div_zero;
    w_abort    = (r_state == ST_ACTIVE) & ~mstr_i;
    w_last     = (r_state == ST_ACTIVE) & w_en & (r_cnt == r_len - LEN_W'(1));
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = w_start ? ST_ACTIVE : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_tip_nxt     = (w_state_nxt == ST_ACTIVE);
    w_ss_nxt      = ~w_tip_nxt;
    w_load_nxt    = w_start;
    w_rx_nxt      = w_last;
    w_abort_nxt   = w_abort;
    w_err_nxt     = w_err;
    w_pending_nxt = pending_o;
    if (!mstr_i) begin
      w_pending_nxt = 1'b0;
    end else if (w_start | w_err) begin
      w_pending_nxt = 1'b0;
    end else if (send_data_i) begin
      // Any request not consumed by a start or an error this cycle is queued.
      w_pending_nxt = 1'b1;
    end
  end

  // Frame length is captured at start so later divisor changes cannot disturb it.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_len_nxt = r_len;
    if (w_start) begin
      w_len_nxt = LEN_W'({BaudRateDivisor_i, 3'b000});
      w_cnt_nxt = '0;
    end else if ((r_state == ST_ACTIVE) & w_en & ~w_last) begin
      w_cnt_nxt = r_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt          <= '0;
      r_len          <= '0;
      ss_o           <= 1'b1;
      tip_o          <= 1'b0;
      load_o         <= 1'b0;
      receive_data_o <= 1'b0;
      abort_o        <= 1'b0;
      err_o          <= 1'b0;
      pending_o      <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_len          <= w_len_nxt;
      ss_o           <= w_ss_nxt;
      tip_o          <= w_tip_nxt;
      load_o         <= w_load_nxt;
      receive_data_o <= w_rx_nxt;
      abort_o        <= w_abort_nxt;
      err_o          <= w_err_nxt;
      pending_o      <= w_pending_nxt;
    end
  end

endmodule
